// File: rtl/serial_subtractor.sv
// Bit-serial subtractor D = A - B - Bin, one bit per clock LSB first, valid/ready on both sides.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output o_ovf.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_b_in,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             o_ovf,
`endif
  output logic             o_bout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [WIDTH-2:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             d_bit, br_nxt;
  logic [WIDTH-1:0] sh_ext;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  // Single full-subtractor cell working on the current LSBs.
  assign d_bit  = a_q[0] ^ b_q[0] ^ br_q;
  assign br_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign sh_ext = {d_bit, sh_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          a_d     = i_a;
          b_d     = i_b;
          br_d    = i_b_in;
          cnt_d   = '0;
          state_d = CALC;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = i_a[WIDTH-1];
          b_msb_d = i_b[WIDTH-1];
`endif
        end
      end
      CALC: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_nxt;
        sh_d  = sh_ext[WIDTH-1:1];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Results are published only here so IDLE/CALC never show a partial value.
          state_d = DONE;
          diff_d  = sh_ext;
          bout_d  = br_nxt;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (a_msb_q != b_msb_q) & (d_bit != a_msb_q);
`endif
        end
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      sh_q    <= '0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign o_diff  = diff_q;
  assign o_bout  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign o_ovf   = ovf_q;
`endif

endmodule
